// File: rtl/gate2_truth_checker.sv
// Exhaustive on-board tester for a 2-input gate: steps through vectors 00..11,
// waits a settle interval per vector, samples the gate and checks it against TT.
module gate2_truth_checker #(
    parameter logic [3:0]  TT            = 4'b0001,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned VEC_W   = 2;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned MASK_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // With no settle interval each vector is sampled on the cycle after it is driven.
    localparam state_t RUN_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                mismatch_c;

    assign mismatch_c = (dut_y != TT[vec_q]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    err_d   = '0;
                    mask_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = RUN_ST;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_d          = err_q + ERR_W'(1);
                    mask_d[vec_q]  = 1'b1;
                end
                if (vec_q != LAST_VEC) begin
                    vec_d      = vec_q + VEC_W'(1);
                    {a_d, b_d} = vec_q + VEC_W'(1);
                    cnt_d      = CNT_LOAD;
                    state_d    = RUN_ST;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_a     = a_q;
    assign dut_b     = b_q;
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: doc/gate2_truth_checker.md
Name: gate2_truth_checker

Overview:
- Synthesizable exhaustive tester for a 2-input combinational gate, such as the lab's CMOS NOR cell.
- It is the driving and checking end of the gate's pin interface. It applies all four input vectors in order, waits a settle interval, samples the gate output, and compares it with a truth-table parameter.
- It reports pass/fail, an error count and a per-vector failure mask, so a gate can be validated on board without a simulator monitor.

Parameters:
- TT, 4'b0001, expected output indexed by {a,b}: TT[0]=y(a0,b0) … TT[3]=y(a1,b1). The default is NOR.
- SETTLE_CYCLES, 1, full clock cycles between driving a vector and sampling dut_y. Legal range is 0..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to run a full check. Honoured only in IDLE or DONE.
- dut_y  input  1  output of the gate under test.
- dut_a  output  1  gate input a (registered).
- dut_b  output  1  gate input b (registered).
- vec_idx  output  2  index {a,b} of the vector currently applied.
- busy  output  1  high while a check is in progress.
- done  output  1  high from completion until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_mask  output  4  bit i set if vector i mismatched.

Behaviour:
- Reset, asynchronous, in any state: state=IDLE, dut_a=0, dut_b=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - vec_idx<=0, {dut_a,dut_b}<=2'b00.
  - err_count<=0, fail_mask<=0, done<=0, pass<=0, busy<=1.
  - counter<=SETTLE_CYCLES.
  - Next state is SETTLE if SETTLE_CYCLES>0, otherwise SAMPLE.
- SETTLE: counter decrements by 1 each edge. On the edge where counter==1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): on the edge, compare dut_y with TT[vec_idx].
  - On mismatch: err_count+1 and fail_mask[vec_idx]<=1.
  - If vec_idx<3: vec_idx+1, drive {dut_a,dut_b}<=new vec_idx, reload counter, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES=0).
  - If vec_idx==3: go to DONE, busy<=0, done<=1. pass<=1 iff the final error total, including this vector, is 0.
- Latency:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises 4*(SETTLE_CYCLES+1) edges after the start-accept edge. With the default this is 8.
- Settle requirement: dut_a/dut_b are held stable for the vector's whole SETTLE and SAMPLE interval. They change only on the start-accept edge or a SAMPLE edge.
- start while busy=1: ignored, with no effect on vector, counts or timing.
- start in DONE: restarts a full run. done drops on the accept edge, and the previous results are cleared on that edge.
- Simultaneous rst and start: rst wins, and the block stays in IDLE.
- rst mid-run: aborts immediately to reset values. Partial results are discarded, and the next start runs all 4 vectors.
- In DONE: dut_a/dut_b hold the last vector (1,1) and vec_idx=3. Results stay stable until start or rst.
- Arithmetic: err_count saturates naturally at 4 and cannot exceed it (3 bits). dut_y is sampled as-is, with no X handling in RTL.

Test Plan:
- Behavioural NOR as DUT, default params: pulse start. Required: vectors 00,01,10,11 each held 2 cycles; done=1 exactly 8 edges after the accept edge; pass=1, err_count=0, fail_mask=4'b0000.
- DUT output stuck at 0, default TT: only vector 00 mismatches. Required: err_count=1, fail_mask=4'b0001, pass=0.
- DUT is an OR gate: all vectors mismatch. Required: err_count=4, fail_mask=4'b1111, pass=0. Then start again from DONE: done drops and the counts clear on the accept edge, and the same results reappear 8 edges later.
- Assert rst for 1 cycle while vec_idx=2: all outputs return to reset values asynchronously, before the next edge. A following start with a correct NOR gives a full 4-vector run and pass=1.
- Pulse start again at 3 edges into a run: there is no change to vec_idx sequence or timing, and done still arrives at edge 8.
- SETTLE_CYCLES=0 and SETTLE_CYCLES=3 with a correct NOR: done arrives 4 and 16 edges after accept respectively. In both cases pass=1, and dut_a/dut_b change only at vector boundaries.
